// File: rtl/alu_seq_pkg.sv
// Shared types, flag indices and op control table for the
// nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC,
    SUB,
    SBC,
    AND,
    XOR,
    OR,
    CP
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    OP1,
    LOW,
    HIGH,
    RES
  } seq_state_t;

  localparam int FLAG_S = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_Y = 5;
  localparam int FLAG_H = 4;
  localparam int FLAG_X = 3;
  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic p;
    logic v;
    logic y;
    logic x;
  } shadow_t;

  // {R,S,V} core controls per op
  function automatic logic [2:0] op_rsv(alu_op_t op);
    logic [2:0] r;
    r = 3'b000;
    case (op)
      AND:     r = 3'b100;
      XOR:     r = 3'b010;
      OR:      r = 3'b110;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic is_sub(alu_op_t op);
    return (op == SUB) || (op == SBC) || (op == CP);
  endfunction

  function automatic logic is_logic(alu_op_t op);
    return (op == AND) || (op == XOR) || (op == OR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Execute-stage handshake to the ALU sequencer: request,
// operands, carry in, and busy/done/F-register back.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic       start;
  alu_op_t    op;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cf_in;
  logic       busy;
  logic       done;
  logic [7:0] flags;

  modport master (
    output start, op, op_a, op_b, cf_in,
    input  busy, done, flags
  );

  modport slave (
    input  start, op, op_a, op_b, cf_in,
    output busy, done, flags
  );

endinterface

// File: rtl/alu_seq_flags.sv
// Combinational F-register assembly from the shadow flags.
// ALU_SEQ_XY_FLAGS_EN exposes the undocumented X/Y bits.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  shadow_t    sh,
  input  alu_op_t    op,
  input  logic       hf,
  output logic [7:0] f
);

  logic n;

  assign n = is_sub(op);

  always_comb begin
    f         = 8'h00;
    f[FLAG_S] = sh.s;
    f[FLAG_Z] = sh.z;
    f[FLAG_N] = n;
    if (is_logic(op)) begin
      f[FLAG_P] = sh.p;
      f[FLAG_H] = (op == AND);
      f[FLAG_C] = 1'b0;
    end else begin
      // carries are raw adder carries; borrow is their inverse
      f[FLAG_P] = sh.v;
      f[FLAG_H] = hf ^ n;
      f[FLAG_C] = sh.c ^ n;
    end
`ifdef ALU_SEQ_XY_FLAGS_EN
    f[FLAG_Y] = sh.y;
    f[FLAG_X] = sh.x;
`endif
  end

`ifndef ALU_SEQ_XY_FLAGS_EN
  logic unused_xy;
  assign unused_xy = sh.x ^ sh.y;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Five-state sequencer driving one 8-bit op through the
// nibble-serial ALU (X/Y flags under ALU_SEQ_XY_FLAGS_EN).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  alu_seq_if.slave   ctl,
  output logic [7:0] db_w,
  output logic       db_w_en,
  output logic       alu_oe,
  output logic       alu_shift_oe,
  output logic       alu_op1_oe,
  output logic       alu_op2_oe,
  output logic       alu_res_oe,
  output logic       alu_op1_sel_bus,
  output logic       alu_op2_sel_bus,
  output logic       alu_sel_op2_neg,
  output logic       alu_sel_op2_high,
  output logic       alu_op_low,
  output logic       alu_core_cf_in,
  output logic       alu_parity_in,
  output logic       alu_core_R,
  output logic       alu_core_S,
  output logic       alu_core_V,
  input  logic       alu_core_cf_out,
  input  logic       alu_parity_out,
  input  logic       alu_zero,
  input  logic       alu_sf_out,
  input  logic       alu_vf_out,
  input  logic       alu_xf_out,
  input  logic       alu_yf_out
);

  seq_state_t state;
  seq_state_t state_d;

  alu_op_t    op_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic       cf_r;
  logic       hf_l;
  logic       pf_l;
  logic       zl_l;
  shadow_t    sh;
  logic [7:0] flags_q;
  logic [7:0] flags_d;
  logic       done_c;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (ctl.start) state_d = OP1;
      OP1:     state_d = LOW;
      LOW:     state_d = HIGH;
      HIGH:    state_d = RES;
      RES:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    db_w             = 8'h00;
    db_w_en          = 1'b0;
    alu_oe           = 1'b0;
    alu_shift_oe     = 1'b0;
    alu_op1_oe       = 1'b0;
    alu_op2_oe       = 1'b0;
    alu_res_oe       = 1'b0;
    alu_op1_sel_bus  = 1'b0;
    alu_op2_sel_bus  = 1'b0;
    alu_sel_op2_neg  = 1'b0;
    alu_sel_op2_high = 1'b0;
    alu_op_low       = 1'b0;
    alu_core_cf_in   = 1'b0;
    alu_parity_in    = 1'b0;
    alu_core_R       = 1'b0;
    alu_core_S       = 1'b0;
    alu_core_V       = 1'b0;
    done_c           = 1'b0;
    unique case (state)
      OP1: begin
        db_w            = a_r;
        db_w_en         = 1'b1;
        alu_shift_oe    = 1'b1;
        alu_op1_sel_bus = 1'b1;
      end
      LOW: begin
        db_w            = b_r;
        db_w_en         = 1'b1;
        alu_shift_oe    = 1'b1;
        alu_op2_sel_bus = 1'b1;
        alu_op_low      = 1'b1;
        alu_sel_op2_neg = is_sub(op_r);
        {alu_core_R, alu_core_S, alu_core_V} = op_rsv(op_r);
        unique case (1'b1)
          op_r == ADC:               alu_core_cf_in = cf_r;
          op_r == SBC:               alu_core_cf_in = ~cf_r;
          op_r == SUB || op_r == CP: alu_core_cf_in = 1'b1;
          default:                   alu_core_cf_in = 1'b0;
        endcase
      end
      HIGH: begin
        alu_sel_op2_high = 1'b1;
        alu_core_cf_in   = hf_l;
        alu_parity_in    = pf_l;
        alu_sel_op2_neg  = is_sub(op_r);
        {alu_core_R, alu_core_S, alu_core_V} = op_rsv(op_r);
      end
      RES: begin
        alu_res_oe = (op_r != CP);
        alu_oe     = (op_r != CP);
        done_c     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      op_r    <= ADD;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      cf_r    <= 1'b0;
      hf_l    <= 1'b0;
      pf_l    <= 1'b0;
      zl_l    <= 1'b0;
      sh      <= '0;
      flags_q <= 8'h00;
    end else begin
      if (state == IDLE && ctl.start) begin
        op_r <= ctl.op;
        a_r  <= ctl.op_a;
        b_r  <= ctl.op_b;
        cf_r <= ctl.cf_in;
      end
      if (state == LOW) begin
        hf_l <= alu_core_cf_out;
        pf_l <= alu_parity_out;
        zl_l <= alu_zero;
      end
      if (state == HIGH) begin
        sh.s <= alu_sf_out;
        sh.z <= zl_l & alu_zero;
        sh.c <= alu_core_cf_out;
        sh.p <= alu_parity_out;
        sh.v <= alu_vf_out;
        sh.y <= alu_yf_out;
        sh.x <= alu_xf_out;
      end
      if (state == RES) flags_q <= flags_d;
    end
  end

  alu_seq_flags u_flags (
    .sh (sh),
    .op (op_r),
    .hf (hf_l),
    .f  (flags_d)
  );

  assign ctl.busy  = (state != IDLE);
  assign ctl.done  = done_c;
  assign ctl.flags = flags_q;

endmodule
